// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter driving open-drain
//               clock/data enables, with inhibit, ack check and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 2500,
    parameter int FIRST_EDGE_TIMEOUT = 375000,
    parameter int EDGE_TIMEOUT       = 50000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_TO_MAX = (FIRST_EDGE_TIMEOUT > EDGE_TIMEOUT) ? FIRST_EDGE_TIMEOUT : EDGE_TIMEOUT;
    localparam int c_TO_W   = $clog2(c_TO_MAX + 1);
    localparam int c_INH_W  = $clog2(INHIBIT_CYCLES + 1);

    localparam logic [c_TO_W-1:0]  c_FIRST_LOAD = c_TO_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [c_TO_W-1:0]  c_EDGE_LOAD  = c_TO_W'(EDGE_TIMEOUT - 1);
    localparam logic [c_INH_W-1:0] c_INH_LOAD   = c_INH_W'(INHIBIT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT   = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_SEND      = 3'd3;
    localparam logic [2:0] c_ST_ACK       = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

    logic [2:0]         r_state;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_byte;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_clk_prev;
    logic               r_data_s1;
    logic               r_data_s2;

    logic        w_fall;
    logic        w_timeout;
    logic        w_line_idle;
    logic        w_abort;
    logic [10:0] w_frame;
    logic [3:0]  w_next_idx;

    assign w_fall      = r_clk_prev & ~r_clk_s2;
    assign w_timeout   = (r_to_cnt == '0);
    assign w_line_idle = r_clk_s2 & r_data_s2;
    assign w_frame     = {1'b1, ~^r_byte, r_byte, 1'b0};
    assign w_next_idx  = r_bit_cnt + 4'd1;

    // Timeout or a high data line at the ack edge both end the frame with an error
    assign w_abort = ((r_state == c_ST_SEND) && !w_fall && w_timeout)
                  || ((r_state == c_ST_ACK) && (w_fall ? r_data_s2 : w_timeout))
                  || ((r_state == c_ST_WAIT_IDLE) && !w_line_idle && w_timeout);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= c_ST_IDLE;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_in;
            r_data_s2  <= r_data_s1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;

            if (w_abort) begin
                r_error   <= 1'b1;
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_busy    <= 1'b0;
                r_state   <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (tx_start) begin
                            r_byte    <= tx_data;
                            r_inh_cnt <= c_INH_LOAD;
                            r_clk_oe  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= c_ST_INHIBIT;
                        end
                    end
                    c_ST_INHIBIT: begin
                        if (r_inh_cnt == '0) begin
                            r_data_oe <= 1'b1;
                            r_state   <= c_ST_START;
                        end else begin
                            r_inh_cnt <= r_inh_cnt - 1'b1;
                        end
                    end
                    c_ST_START: begin
                        // Data stays low: the start bit is already on the line
                        r_clk_oe  <= 1'b0;
                        r_bit_cnt <= '0;
                        r_to_cnt  <= c_FIRST_LOAD;
                        r_state   <= c_ST_SEND;
                    end
                    c_ST_SEND: begin
                        if (w_fall) begin
                            r_bit_cnt <= w_next_idx;
                            r_data_oe <= ~w_frame[w_next_idx];
                            r_to_cnt  <= c_EDGE_LOAD;
                            if (r_bit_cnt == 4'd9) begin
                                r_state <= c_ST_ACK;
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt - 1'b1;
                        end
                    end
                    c_ST_ACK: begin
                        if (w_fall) begin
                            r_to_cnt <= c_EDGE_LOAD;
                            r_state  <= c_ST_WAIT_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt - 1'b1;
                        end
                    end
                    c_ST_WAIT_IDLE: begin
                        if (w_line_idle) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH      = 25;
    localparam int FIRST_TO = 100;
    localparam int EDGE_TO  = 60;
    localparam int HALF     = 8;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (INH),
        .FIRST_EDGE_TIMEOUT (FIRST_TO),
        .EDGE_TIMEOUT       (EDGE_TO)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    // Wired-AND open-drain bus: either side may pull a line low
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always @(negedge clk) begin
        if (tx_done)             done_cnt++;
        if (tx_error)            err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Requests a frame and plays the device side for 'edges' clock pulses
    task automatic send_frame(input logic [7:0] b, input bit ack, input bit glitch, input int edges,
                              output logic [10:0] cap, output bit ok_lat, output bit timed_out);
        int n;
        cap       = '0;
        ok_lat    = 1'b1;
        timed_out = 1'b0;
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            tx_data  = 8'h00;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end
        n = 0;
        while (ps2_clk_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe) begin
            timed_out = 1'b1;
            return;
        end
        repeat (5) @(negedge clk);
        cap[0] = ps2_data_in;
        for (int k = 1; k <= edges; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                @(negedge clk);
            end
            dev_clk_low = 1'b1;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (k == 1 && c == 2 && ps2_data_oe !== 1'b1)  ok_lat = 1'b0;
                if (k == 1 && c == 3 && ps2_data_oe !== ~b[0]) ok_lat = 1'b0;
            end
            if (k <= 10) cap[k] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            dev_data_low = 1'b0;
            repeat (HALF - 2) @(negedge clk);
        end
    endtask

    // Waits (bounded) for a done/error pulse, then checks the frame outcome
    task automatic finish_frame(input string tag, input int d0, input int e0,
                                input bit exp_done, input bit exp_err);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done"},  done_cnt - d0, {31'd0, exp_done});
        check({tag, "_error"}, err_cnt - e0,  {31'd0, exp_err});
        check({tag, "_busy_after"}, tx_busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        bit          glitch;
        logic [10:0] exp_frame;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [10:0] cap;
        bit          ok_lat;
        bit          tmo;
        int          d0;
        int          e0;
        int          bad_clk;
        int          bad_data;
        int          bad_busy;
        int          err_at;
        int          err_pulses;
        logic [7:0]  rb;
        bit          rack;

        vecs[0] = '{8'hED, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0};
        vecs[3] = '{8'hED, 1'b0, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_clk_oe",  ps2_clk_oe,  1'b0);
        check("reset_data_oe", ps2_data_oe, 1'b0);
        check("reset_busy",    tx_busy,     1'b0);
        check("reset_done",    tx_done,     1'b0);
        check("reset_error",   tx_error,    1'b0);
        nreset = 1'b1;
        repeat (3) @(negedge clk);

        // No device: inhibit, start, then first-edge timeout
        d0 = done_cnt;
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        check("idle_clk_oe_before_start", ps2_clk_oe, 1'b0);
        @(negedge clk);
        tx_start   = 1'b0;
        bad_clk    = 0;
        bad_data   = 0;
        bad_busy   = 0;
        err_at     = -1;
        err_pulses = 0;
        for (int j = 0; j <= 140; j++) begin
            if (ps2_clk_oe  !== (j <= INH))                       bad_clk++;
            if (ps2_data_oe !== (j >= INH && j < INH + 1 + FIRST_TO)) bad_data++;
            if (tx_busy     !== (j < INH + 1 + FIRST_TO))         bad_busy++;
            if (tx_error) begin
                err_pulses++;
                err_at = j;
            end
            if (j < 140) @(negedge clk);
        end
        check("timeout_error_cycle",   err_at,     INH + 1 + FIRST_TO);
        check("timeout_error_pulses",  err_pulses, 1);
        check("timeout_clk_oe_profile",  bad_clk,  0);
        check("timeout_data_oe_profile", bad_data, 0);
        check("timeout_busy_profile",    bad_busy, 0);
        check("timeout_no_done", done_cnt - d0, 0);

        // Directed frames from the table
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].ack, vecs[i].glitch, 11, cap, ok_lat, tmo);
            check($sformatf("vec%0d_release", i), tmo, 1'b0);
            check($sformatf("vec%0d_frame", i),   cap, vecs[i].exp_frame);
            check($sformatf("vec%0d_edge_latency", i), ok_lat, 1'b1);
            finish_frame($sformatf("vec%0d", i), d0, e0, vecs[i].exp_done, vecs[i].exp_err);
        end

        // Reset asserted mid-frame after the fourth device edge
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 4, cap, ok_lat, tmo);
        check("midreset_busy_before",    tx_busy,     1'b1);
        check("midreset_data_oe_before", ps2_data_oe, 1'b1);
        #2;
        nreset = 1'b0;
        #1;
        check("midreset_lines_released", {ps2_clk_oe, ps2_data_oe, tx_busy}, 3'b000);
        repeat (3) @(negedge clk);
        check("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hF4, 1'b1, 1'b0, 11, cap, ok_lat, tmo);
        check("after_reset_frame", cap, model_frame(8'hF4));
        finish_frame("after_reset", d0, e0, 1'b1, 1'b0);

        // Randomised frames against the reference model
        for (int r = 0; r < 8; r++) begin
            rb   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(rb, rack, 1'b0, 11, cap, ok_lat, tmo);
            check($sformatf("rand%0d_frame_%02h", r, rb), cap, model_frame(rb));
            finish_frame($sformatf("rand%0d", r), d0, e0, rack, ~rack);
        end

        check("done_error_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGC5 to the keyboard. It complements the existing scan-code receiver on the PS/2 port. It drives the shared PS2_clk/PS2_data lines as open-drain outputs through the top-level pads, and reports completion or failure to the Memory Unit I/O register logic. While tx_busy is high, the receiver path ignores the lines.

## Interface
- INHIBIT_CYCLES, 2500: clk cycles the PS/2 clock is held low before the request (100 µs at 25 MHz).
- FIRST_EDGE_TIMEOUT, 375000: max cycles from releasing the PS/2 clock to the first device falling edge (15 ms).
- EDGE_TIMEOUT, 50000: max cycles between later device falling edges, and in WAIT_IDLE (2 ms).
- clk  in  1  system clock, 25 MHz.
- nreset  in  1  asynchronous active-low reset.
- tx_start  in  1  one-cycle request; sampled only in IDLE.
- tx_data  in  8  byte to send; latched on accepted tx_start.
- ps2_clk_in  in  1  raw PS/2 clock pad level, unsynchronised.
- ps2_data_in  in  1  raw PS/2 data pad level, unsynchronised.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- tx_busy  out  1  high from the cycle after an accepted tx_start until the return to IDLE.
- tx_done  out  1  one-cycle pulse when a frame is acknowledged.
- tx_error  out  1  one-cycle pulse on timeout or missing ack.

## Operation
- Inputs pass through 2-flop synchronisers and a previous-sample register. A falling edge is detected when prev=1 and cur=0.
- Frame order: start bit (0), D0..D7 LSB first, odd parity = ~^tx_data, stop bit (1 = release), device ack (device pulls data low).
- A bit value b is driven as ps2_data_oe = ~b.
- States and transitions:
  - IDLE: both oe=0, busy=0. An accepted tx_start latches the byte and goes to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0, for INHIBIT_CYCLES cycles, then START.
  - START: clk_oe=1, data_oe=1, for exactly 1 cycle, then SEND with bitcnt=0 and the timeout counter loaded with FIRST_EDGE_TIMEOUT.
  - SEND: clk_oe=0, data_oe holds the current bit (start bit first). On each falling edge, bitcnt increments and data_oe takes the next bit: edges 1–8 give D0–D7, edge 9 gives parity, edge 10 gives stop (data_oe=0). Edge 10 moves to ACK. Each edge reloads the timeout counter with EDGE_TIMEOUT.
  - ACK: both oe=0. On the next falling edge, sample the synced data. If 0, go to WAIT_IDLE. If 1, pulse tx_error and go to IDLE.
  - WAIT_IDLE: both oe=0. When synced clk=1 and data=1, pulse tx_done and go to IDLE.
- Timeout: a timeout counter expiring in SEND, ACK or WAIT_IDLE pulses tx_error, releases both lines the same cycle and goes to IDLE.
- tx_start in any state other than IDLE is ignored. The latched byte is unaffected and no pulse is generated.
- tx_done and tx_error never assert together.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, state=IDLE. Asserting nreset mid-frame releases both lines immediately, with no pulse.
- Latency:
  - tx_start → clk_oe=1 in 1 cycle.
  - clk_oe stays high for INHIBIT_CYCLES+1 cycles in total (the last of those is the START cycle, where data_oe is also 1).
  - Pad falling edge → data_oe update in 3 cycles (2 sync stages + edge register).
- Counter widths: the timeout counter is ≥19 bits; the inhibit counter is ≥12 bits. Widths scale with the parameters via $clog2.
- Immediately after the IDLE transition, tx_busy=0, so a new tx_start is accepted the next cycle.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and sending an ack → data line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done pulses once, tx_error stays 0.
- Send 0x01 → parity bit 0. Send 0x00 → parity 1. Both end with tx_done.
- No device clock (INHIBIT_CYCLES=25, FIRST_EDGE_TIMEOUT=100 override) → tx_error pulses exactly 126 cycles after the accepted tx_start. Both oe=0 afterwards.
- Device clocks 11 edges but leaves data high at the ack edge → tx_error pulses, no tx_done.
- Send 0xFF and pulse tx_start with 0x00 during INHIBIT → ignored. The frame carries 0xFF with parity 1.
- Deassert nreset at bit 4 → the same cycle both oe=0 and busy=0. After reset, send 0xF4 → transmits normally.
